hex_display_ctrl: RTL and testbench

HEX_DISPLAY_CTRL -- requirements
Module: hex_display_ctrl

---
 rtl/hex_display_ctrl.sv | 145 ++++++++++++++
 tb/tb_hex_display_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_display_ctrl.sv
// hex_display_ctrl: drives NUM_DIGITS active-low 7-segment digits from a
// loadable hex register. It supports a per-digit hide mask, leading-zero
// blanking and an optional whole-display blink.
// Define HEX_DISPLAY_BLINK_EN to build the blink counter. When it is not
// defined, the blink input is ignored and the display never blinks.
`default_nettype none

module hex_display_ctrl #(
  parameter int NUM_DIGITS = 6,
  parameter int BLINK_DIV  = 25000000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic                    freeze,
  input  logic                    lz_en,
  input  logic [NUM_DIGITS-1:0]   hide,
  input  logic                    blink,
  output logic [7*NUM_DIGITS-1:0] leds,
  output logic                    busy_n
);

  localparam int CNT_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

  logic [4*NUM_DIGITS-1:0] val_q, val_d;
  logic [7*NUM_DIGITS-1:0] leds_q, leds_d;
  logic                    busy_q, busy_d;
  logic                    blink_phase_q;

  // Segment pattern for one nibble. Bits are gfedcba, and 0 lights a segment.
  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

`ifdef HEX_DISPLAY_BLINK_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             blink_phase_d;

  // Blink timing: count while blink is held and flip the phase on each wrap.
  // Dropping blink clears the counter and phase so the next blink starts visible.
  always_comb begin
    cnt_d         = cnt_q;
    blink_phase_d = blink_phase_q;
    if (!blink) begin
      cnt_d         = '0;
      blink_phase_d = 1'b0;
    end else if (cnt_q == CNT_W'(BLINK_DIV - 1)) begin
      cnt_d         = '0;
      blink_phase_d = ~blink_phase_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Blink counter and phase registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q         <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end
`else
  logic unused_blink;
  assign unused_blink  = blink;
  assign blink_phase_q = 1'b0;
`endif

  // Next display register and busy flag. Freeze has priority over load.
  always_comb begin
    val_d  = val_q;
    busy_d = ~freeze;
    if (load && !freeze) begin
      val_d = value;
    end
  end

  // Segment outputs, scanning from the top digit down.
  // Leading-zero blanking stays on only while every nibble seen so far is zero.
  // Digit 0 is never blanked this way, so a zero value still shows a single "0".
  always_comb begin
    logic       upper_zero;
    logic [3:0] nib;
    logic       lz_blank;
    leds_d     = '1;
    upper_zero = 1'b1;
    nib        = 4'h0;
    lz_blank   = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      nib        = val_q[4*i +: 4];
      upper_zero = upper_zero & (nib == 4'h0);
      lz_blank   = lz_en & (i != 0) & upper_zero;
      if (blink_phase_q) begin
        leds_d[7*i +: 7] = 7'b1111111;
      end else if (hide[i]) begin
        leds_d[7*i +: 7] = 7'b1111111;
      end else if (lz_blank) begin
        leds_d[7*i +: 7] = 7'b1111111;
      end else begin
        leds_d[7*i +: 7] = seg7(nib);
      end
    end
  end

  // Display register, registered segments and registered busy flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      val_q  <= '0;
      leds_q <= '1;
      busy_q <= 1'b0;
    end else begin
      val_q  <= val_d;
      leds_q <= leds_d;
      busy_q <= busy_d;
    end
  end

  assign leds   = leds_q;
  assign busy_n = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_hex_display_ctrl.sv
// Testbench for hex_display_ctrl with four digits and a blink half-period of 4.
// A cycle model pushes the expected outputs for each edge into a scoreboard.
// Each directed step also checks fixed segment patterns.
module tb_hex_display_ctrl;

  localparam int ND = 4;
  localparam int BD = 4;

  logic            clk;
  logic            reset;
  logic [4*ND-1:0] value;
  logic            load;
  logic            freeze;
  logic            lz_en;
  logic [ND-1:0]   hide;
  logic            blink;
  logic [7*ND-1:0] leds;
  logic            busy_n;

  typedef struct packed {
    logic [7*ND-1:0] leds;
    logic            busy_n;
  } exp_t;

  exp_t        sb[$];
  int          checks;
  int          errors;
  logic [15:0] m_val;
  int          m_cnt;
  logic        m_phase;

  localparam logic [6:0] BLK = 7'b1111111;

  hex_display_ctrl #(.NUM_DIGITS(ND), .BLINK_DIV(BD)) dut (
    .clk    (clk),
    .reset  (reset),
    .value  (value),
    .load   (load),
    .freeze (freeze),
    .lz_en  (lz_en),
    .hide   (hide),
    .blink  (blink),
    .leds   (leds),
    .busy_n (busy_n)
  );

  // Free-running clock with rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stop a runaway simulation with a report instead of hanging.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [6:0] segOf(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
          7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
          7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
          7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    return t[n];
  endfunction

  function automatic logic [7*ND-1:0] modelLeds(input logic [15:0] v, input logic [ND-1:0] h,
                                                input logic lz, input logic ph);
    logic [7*ND-1:0] r;
    logic            off;
    r = '1;
    for (int i = 0; i < ND; i++) begin
      off = ph || h[i] || (lz && i > 0 && (v >> (4 * i)) == 16'h0);
      r[7*i +: 7] = off ? BLK : segOf(v[4*i +: 4]);
    end
    return r;
  endfunction

  task automatic checkVal(input string tag, input logic [7*ND-1:0] obs, input logic [7*ND-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("[TB] FAIL scoreboard: observed empty expected entry");
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checkVal("sb_leds", leds, e.leds);
      checkVal("sb_busy_n", {27'b0, busy_n}, {27'b0, e.busy_n});
    end
  endtask

  // Record the expected outputs for the coming edge, advance the model, run one
  // edge and compare the results.
  task automatic applyStimulus();
    exp_t e;
    e.leds   = modelLeds(m_val, hide, lz_en, m_phase);
    e.busy_n = ~freeze;
    sb.push_back(e);
    if (load && !freeze) m_val = value;
`ifdef HEX_DISPLAY_BLINK_EN
    if (!blink) begin
      m_cnt   = 0;
      m_phase = 1'b0;
    end else if (m_cnt == BD - 1) begin
      m_cnt   = 0;
      m_phase = ~m_phase;
    end else begin
      m_cnt++;
    end
`endif
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic modelReset();
    m_val   = 16'h0;
    m_cnt   = 0;
    m_phase = 1'b0;
    sb.delete();
  endtask

  logic [7*ND-1:0] beef;
  logic            blank_exp;

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    value  = '0;
    load   = 1'b0;
    freeze = 1'b0;
    lz_en  = 1'b0;
    hide   = '0;
    blink  = 1'b0;
    modelReset();
    beef = {7'b0000011, 7'b0000110, 7'b0000110, 7'b0001110};

    // Check the reset state, then release reset between edges.
    #12;
    checkVal("reset_leds", leds, '1);
    checkVal("reset_busy_n", {27'b0, busy_n}, 28'd0);
    reset = 1'b0;
    applyStimulus();
    checkVal("post_reset_zero", leds, {4{7'b1000000}});

    // Load 12AF. The digits appear two edges after load is sampled.
    value = 16'h12AF; load = 1'b1;
    applyStimulus();
    load = 1'b0;
    applyStimulus();
    checkVal("load_12AF", leds, {7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110});

    // Leading-zero blanking.
    lz_en = 1'b1; value = 16'h0030; load = 1'b1;
    applyStimulus();
    load = 1'b0;
    applyStimulus();
    checkVal("lz_0030", leds, {BLK, BLK, 7'b0110000, 7'b1000000});
    value = 16'h0000; load = 1'b1;
    applyStimulus();
    load = 1'b0;
    applyStimulus();
    checkVal("lz_0000", leds, {BLK, BLK, BLK, 7'b1000000});
    value = 16'h1020; load = 1'b1;
    applyStimulus();
    load = 1'b0;
    applyStimulus();
    checkVal("lz_1020", leds, {7'b1111001, 7'b1000000, 7'b0100100, 7'b1000000});

    // Freeze rises on the same edge as load, so BEEF must not be captured.
    lz_en = 1'b0; freeze = 1'b1; value = 16'hBEEF; load = 1'b1;
    applyStimulus();
    applyStimulus();
    checkVal("freeze_hold", leds, {7'b1111001, 7'b1000000, 7'b0100100, 7'b1000000});
    checkVal("freeze_busy_n", {27'b0, busy_n}, 28'd0);
    freeze = 1'b0;
    applyStimulus();
    load = 1'b0;
    applyStimulus();
    checkVal("unfreeze_BEEF", leds, beef);
    checkVal("unfreeze_busy_n", {27'b0, busy_n}, 28'd1);

    // Per-digit hide mask.
    hide = 4'b0101;
    applyStimulus();
    checkVal("hide_0101", leds, {7'b0000011, BLK, 7'b0000110, BLK});
    hide = 4'b0000;
    applyStimulus();

    // Blink for 16 edges. Without blink support the display must stay lit.
    blink = 1'b1;
    for (int k = 0; k < 16; k++) begin
      applyStimulus();
`ifdef HEX_DISPLAY_BLINK_EN
      blank_exp = ((k / 4) % 2) == 1;
`else
      blank_exp = 1'b0;
`endif
      checkVal($sformatf("blink_edge%0d", k + 1), leds, blank_exp ? '1 : beef);
    end
    blink = 1'b0;
    applyStimulus();
    checkVal("blink_off_visible", leds, beef);

    // Random loads with random hide and lz settings, checked against the model.
    for (int r = 0; r < 8; r++) begin
      value = 16'($urandom);
      hide  = 4'($urandom_range(0, 15));
      lz_en = 1'($urandom_range(0, 1));
      load  = 1'b1;
      applyStimulus();
      load = 1'b0;
      applyStimulus();
    end
    hide = '0; lz_en = 1'b0;

    // Assert reset between edges while a load is pending.
    value = 16'h1234; load = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    checkVal("midreset_leds", leds, '1);
    checkVal("midreset_busy_n", {27'b0, busy_n}, 28'd0);
    @(posedge clk);
    #1;
    load  = 1'b0;
    reset = 1'b0;
    modelReset();
    applyStimulus();
    checkVal("release_val_zero", leds, {4{7'b1000000}});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
